// File: rtl/rr_arbiter_eight.sv
// =============================================================================
// rr_arbiter_eight : 8-way round-robin arbiter, registered one-hot grant with
//                    encoded index and hold timeout.
// Revision: 1.0
// =============================================================================
`default_nettype none

module rr_arbiter_eight #(
   parameter int N        = 8,
   parameter int IDXW     = 3,
   parameter int MAX_HOLD = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req_i,
   input  logic            done_i,
   output logic [N-1:0]    grant_o,
   output logic [IDXW-1:0] grant_idx_o,
   output logic            grant_valid_o,
   output logic            timeout_o
);

   localparam int CNTW = $clog2(MAX_HOLD);
   localparam logic [CNTW-1:0] c_cnt_last = CNTW'(MAX_HOLD - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   ptr_q,   ptr_d;
   logic [CNTW-1:0]   cnt_q,   cnt_d;
   logic [N-1:0]      grant_q, grant_d;
   logic [IDXW-1:0]   idx_q,   idx_d;
   logic              timeout_q, timeout_d;

   logic [IDXW-1:0]   w_sel;
   logic              w_found;
   logic              w_rel_done;
   logic              w_rel_wd;
   logic              w_rel_to;

   // Scan starting at the priority pointer; the 3-bit add wraps 7 -> 0.
   always_comb begin
      w_sel   = '0;
      w_found = 1'b0;
      for (int i = 0; i < N; i++) begin
         logic [IDXW-1:0] cand;
         cand = ptr_q + IDXW'(i);
         if (!w_found && req_i[cand]) begin
            w_sel   = cand;
            w_found = 1'b1;
         end
      end
   end

   assign w_rel_done = done_i;
   assign w_rel_wd   = ~req_i[idx_q];
   assign w_rel_to   = (cnt_q == c_cnt_last);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      grant_d   = grant_q;
      idx_d     = idx_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (w_found) begin
               grant_d = {{(N-1){1'b0}}, 1'b1} << w_sel;
               idx_d   = w_sel;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (w_rel_done || w_rel_wd || w_rel_to) begin
               grant_d   = '0;
               idx_d     = '0;
               cnt_d     = '0;
               ptr_d     = idx_q + 1'b1;
               state_d   = IDLE;
               // Done or withdrawal on the same edge masks the timeout.
               timeout_d = w_rel_to && !w_rel_done && !w_rel_wd;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         cnt_q     <= '0;
         grant_q   <= '0;
         idx_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         grant_q   <= grant_d;
         idx_q     <= idx_d;
         timeout_q <= timeout_d;
      end
   end

   assign grant_o       = grant_q;
   assign grant_idx_o   = idx_q;
   assign grant_valid_o = |grant_q;
   assign timeout_o     = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_eight.sv
// =============================================================================
// tb_rr_arbiter_eight : directed self-checking bench for rr_arbiter_eight.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_rr_arbiter_eight;

   logic       clk;
   logic       rst;
   logic [7:0] req_i;
   logic       done_i;
   logic [7:0] grant_o;
   logic [2:0] grant_idx_o;
   logic       grant_valid_o;
   logic       timeout_o;

   int checks = 0;
   int errors = 0;

   rr_arbiter_eight #(
      .N        (8),
      .IDXW     (3),
      .MAX_HOLD (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_i         (req_i),
      .done_i        (done_i),
      .grant_o       (grant_o),
      .grant_idx_o   (grant_idx_o),
      .grant_valid_o (grant_valid_o),
      .timeout_o     (timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge, sample 1ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [7:0] eg,
                            input logic [2:0] ei, input logic ev, input logic et);
      checks++;
      assert (grant_o === eg) else begin
         errors++;
         $error("FAIL %s grant: observed %h expected %h", tag, grant_o, eg);
      end
      checks++;
      assert (grant_idx_o === ei) else begin
         errors++;
         $error("FAIL %s grant_idx: observed %0d expected %0d", tag, grant_idx_o, ei);
      end
      checks++;
      assert (grant_valid_o === ev) else begin
         errors++;
         $error("FAIL %s grant_valid: observed %b expected %b", tag, grant_valid_o, ev);
      end
      checks++;
      assert (timeout_o === et) else begin
         errors++;
         $error("FAIL %s timeout: observed %b expected %b", tag, timeout_o, et);
      end
   endtask

   function automatic logic [7:0] onehot(input int k);
      return 8'(1) << k;
   endfunction

   initial begin
      rst    = 1'b1;
      req_i  = 8'h00;
      done_i = 1'b0;
      step();
      step();
      check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);

      // Single requester on bit 2
      rst   = 1'b0;
      req_i = 8'h04;
      step();
      check_out("t1_grant", 8'h04, 3'd2, 1'b1, 1'b0);
      req_i = 8'h00;
      step();
      check_out("t1_release", 8'h00, 3'd0, 1'b0, 1'b0);
      step();
      check_out("t1_idle", 8'h00, 3'd0, 1'b0, 1'b0);

      // Full rotation from a fresh pointer
      rst = 1'b1;
      step();
      rst   = 1'b0;
      req_i = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         step();
         check_out("t2_grant", onehot(i % 8), 3'(i % 8), 1'b1, 1'b0);
         step();
         done_i = 1'b1;
         step();
         check_out("t2_gap", 8'h00, 3'd0, 1'b0, 1'b0);
         done_i = 1'b0;
      end
      // Pointer now 1
      req_i = 8'h08;
      step();
      check_out("t3_grant", 8'h08, 3'd3, 1'b1, 1'b0);
      for (int i = 1; i < 16; i++) begin
         step();
         if (i == 8 || i == 15)
            check_out("t3_hold", 8'h08, 3'd3, 1'b1, 1'b0);
      end
      step();
      check_out("t3_timeout", 8'h00, 3'd0, 1'b0, 1'b1);
      req_i = 8'h18;
      step();
      check_out("t3_next", 8'h10, 3'd4, 1'b1, 1'b0);

      // done coincides with the final hold cycle
      for (int i = 0; i < 15; i++) step();
      check_out("t4_hold", 8'h10, 3'd4, 1'b1, 1'b0);
      done_i = 1'b1;
      step();
      check_out("t4_done_wins", 8'h00, 3'd0, 1'b0, 1'b0);
      done_i = 1'b0;

      // Reset while busy on idx 5 (pointer is 5)
      req_i = 8'h20;
      step();
      check_out("t5_grant", 8'h20, 3'd5, 1'b1, 1'b0);
      step();
      rst   = 1'b1;
      req_i = 8'h81;
      step();
      check_out("t5_reset", 8'h00, 3'd0, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      check_out("t5_ptr0", 8'h01, 3'd0, 1'b1, 1'b0);
      req_i = 8'h00;
      step();
      check_out("t5_release", 8'h00, 3'd0, 1'b0, 1'b0);

      // Withdrawal mid-grant on idx 6, then wrap
      req_i = 8'h40;
      step();
      check_out("t6_grant", 8'h40, 3'd6, 1'b1, 1'b0);
      step();
      req_i = 8'h00;
      step();
      check_out("t6_withdraw", 8'h00, 3'd0, 1'b0, 1'b0);
      req_i = 8'h41;
      step();
      check_out("t6_wrap", 8'h01, 3'd0, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
